instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder counterpart of the control decoder: accepts symbolic instruction commands (mnemonic select plus register and immediate fields) over a valid/ready handshake.
- Assembles each command into a 32-bit MIPS word for the same instruction subset the decoder supports.
- Buffers words in a small FIFO and streams them out with their target instruction-memory byte address.
- Used by the bench/loader path to fill instruction memory ahead of CPU release.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word and of every restart.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- restart  in  1  sync pulse: flush FIFO, reload address counter, clear err, FSM to RUN.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid&in_ready.
- in_mnem  in  5  0 add,1 sub,2 and,3 or,4 slt,5 sltu,6 addu,7 subu,8 sll,9 nor,10 addi,11 ori,12 lw,13 sw,14 beq,15 j,16 jal,17-31 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_imm  in  26  immediate (low 16 bits used) or jump target (all 26).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops when out_valid&out_ready.
- out_instr  out  32  encoded word at FIFO head.
- out_addr  out  32  byte address of out_instr.
- err  out  1  sticky: an illegal mnemonic was accepted.
- illegal_cnt  out  8  saturating count of illegal commands accepted.

Behaviour:
- Reset (rstn=0, async): FIFO empty, out_valid=0, out_instr=0, out_addr=0, err=0, illegal_cnt=0, addr counter=BASE_ADDR, FSM=RUN.
- R-type encoding: op=0, {rs,rt,rd,shamt,funct}.
  - funct: add 20, sub 22, and 24, or 25, slt 2A, sltu 2B, addu 21, subu 23, nor 27 (hex).
  - sll: funct 00, rs=0, uses rd/rt/shamt; all other R-type force shamt=0.
- I-type: {op,rs,rt,imm[15:0]}; op addi 08, ori 0D, lw 23, sw 2B, beq 04.
- J-type: {op,imm[25:0]}; op j 02, jal 03.
- in_ready = (FSM==RUN) & ~full & ~restart; registered count only, so a pop in the same cycle does not free space for a push.
- Legal accept at cycle N: word pushed with current addr counter value; counter += 4 (wraps mod 2^32); out_valid=1 at N+1 if FIFO was empty.
- Illegal accept: handshake completes; nothing pushed; counter unchanged; err=1 and illegal_cnt+1 (saturating at 255) at N+1.
- FIFO: first-in first-out; out_instr/out_addr hold stable while out_valid & ~out_ready.
- Simultaneous push and pop when not full: both occur, count unchanged.
- Restart: takes priority over push, pop and pad; next cycle out_valid=0 and next emitted address = BASE_ADDR.
- FSM states: RUN (normal) and PAD (only with the optional feature); PAD is never entered without it.
- rstn asserted mid-operation: immediate return to reset values; FIFO contents lost.

Optional Feature:
- Macro: INSTR_ENCODER_DELAY_SLOT_EN.
- Defined: a legal accept of beq, j or jal moves RUN->PAD.
  - In PAD, in_ready=0; when not full, push NOP 32'h0000_0000 at the next address, then return to RUN.
  - restart in PAD returns to RUN with no NOP pushed.
- Undefined: no PAD state; branches and jumps are emitted alone.

Test Plan:
- Reset then add rs=1,rt=2,rd=3 -> one cycle later out_valid=1, out_instr=32'h0022_1820, out_addr=BASE_ADDR.
- addi rs=0,rt=8,imm=26'h3FF_FFFB; lw rs=29,rt=9,imm=4; j imm=26'h010_0000 -> 32'h2008_FFFB, 32'h8FA9_0004, 32'h0810_0000 at addrs 0,4,8.
- Hold out_ready=0, push 5 commands with FIFO_DEPTH=4 -> in_ready low after 4th accept; release -> 5 words in order, no loss or duplication.
- in_mnem=20 accepted -> err=1, illegal_cnt=1, no push; following sll rd=4,rt=5,shamt=2 -> 32'h0005_2080 at next unused address.
- With macro: beq rs=1,rt=2,imm=3 -> 32'h1022_0003 at addr 0, NOP at addr 4, in_ready low exactly one cycle; without macro -> no NOP.
- restart with 3 words queued and in_valid=1 -> command not accepted, out_valid=0 next cycle, next push at BASE_ADDR; rstn pulse mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: assembles symbolic MIPS commands into 32-bit words and streams them with byte addresses through a FIFO.
// Define INSTR_ENCODER_DELAY_SLOT_EN to append a NOP after every beq/j/jal.
module instr_encoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [25:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  illegal_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {RUN, PAD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [31:0]     addr_mem_q  [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic [31:0]     addr_q;
    logic            err_q;
    logic [7:0]      ill_q;
    logic [5:0]      funct, op;
    logic [31:0]     enc, push_word;
    logic            legal, full, accept, pad_push, push, pop;

    always_comb begin
        funct = 6'h00;
        op    = 6'h00;
        legal = 1'b1;
        case (in_mnem)
            5'd0:  funct = 6'h20;
            5'd1:  funct = 6'h22;
            5'd2:  funct = 6'h24;
            5'd3:  funct = 6'h25;
            5'd4:  funct = 6'h2A;
            5'd5:  funct = 6'h2B;
            5'd6:  funct = 6'h21;
            5'd7:  funct = 6'h23;
            5'd8:  funct = 6'h00;
            5'd9:  funct = 6'h27;
            5'd10: op = 6'h08;
            5'd11: op = 6'h0D;
            5'd12: op = 6'h23;
            5'd13: op = 6'h2B;
            5'd14: op = 6'h04;
            5'd15: op = 6'h02;
            5'd16: op = 6'h03;
            default: legal = 1'b0;
        endcase
        // sll is the only R-type that takes shamt and ignores rs
        enc = in_mnem <= 5'd9  ? {6'h00, (in_mnem == 5'd8) ? 5'd0 : in_rs, in_rt, in_rd,
                                  (in_mnem == 5'd8) ? in_shamt : 5'd0, funct} :
              in_mnem >= 5'd15 ? {op, in_imm} :
                                 {op, in_rs, in_rt, in_imm[15:0]};
    end

    assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign out_valid = cnt_q != '0;
    assign in_ready  = state_q == RUN && !full && !restart;
    assign accept    = in_valid && in_ready;
    assign pad_push  = state_q == PAD && !full && !restart;
    assign push      = (accept && legal) || pad_push;
    assign pop       = out_valid && out_ready && !restart;
    assign push_word = pad_push ? 32'h0000_0000 : enc;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q] : 32'h0;
    assign err         = err_q;
    assign illegal_cnt = ill_q;

`ifdef INSTR_ENCODER_DELAY_SLOT_EN
    logic is_br;
    assign is_br = in_mnem == 5'd14 || in_mnem == 5'd15 || in_mnem == 5'd16;
    always_comb begin
        state_d = restart            ? RUN :
                  state_q == PAD     ? (full ? PAD : RUN) :
                  accept && legal && is_br ? PAD : RUN;
    end
`else
    always_comb begin
        state_d = RUN;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
            ill_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (restart) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                addr_q   <= BASE_ADDR;
                err_q    <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    addr_q   <= addr_q + 32'd4;
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
                if (accept && !legal) begin
                    err_q <= 1'b1;
                    ill_q <= ill_q + 8'(ill_q != 8'hFF);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= push_word;
            addr_mem_q[wr_ptr_q]  <= addr_q;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a table-driven MIPS encoding model.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk, rstn, restart, in_valid, in_ready, out_valid, out_ready, err;
    logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
    logic [25:0] in_imm;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  illegal_cnt;

    int errors = 0, checks = 0;
    logic [63:0] exp_q [$];
    logic [31:0] m_addr;
    bit          m_err;
    int          m_ill;
    int rfunct [10] = '{32, 34, 36, 37, 42, 43, 33, 35, 0, 39};
    int iop    [7]  = '{8, 13, 35, 43, 4, 2, 3};

    instr_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rstn(rstn), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_word(input int m, input int rs, input int rt, input int rd,
                                             input int sh, input int imm);
        longint w;
        if (m < 10)
            w = longint'((m == 8 ? 0 : rs) * 2097152 + rt * 65536 + rd * 2048 + (m == 8 ? sh : 0) * 64 + rfunct[m]);
        else if (m < 15)
            w = longint'(iop[m-10]) * 67108864 + longint'(rs * 2097152 + rt * 65536 + imm % 65536);
        else
            w = longint'(iop[m-10]) * 67108864 + longint'(imm);
        return w[31:0];
    endfunction

    // Presents one command until accepted and advances the model; returns at posedge+1 after acceptance.
    task automatic send(input int m, input int rs, input int rt, input int rd, input int sh,
                        input int imm, input bit mdl);
        bit done = 1'b0;
        in_valid = 1'b1; in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt);
        in_rd = 5'(rd); in_shamt = 5'(sh); in_imm = 26'(imm);
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            if (in_ready) begin
                done = 1'b1;
                if (m <= 16) begin
                    if (mdl) exp_q.push_back({ref_word(m, rs, rt, rd, sh, imm), m_addr});
                    m_addr += 32'd4;
                    if (DS && m >= 14) begin
                        if (mdl) exp_q.push_back({32'h0, m_addr});
                        m_addr += 32'd4;
                    end
                end else begin
                    m_err = 1'b1;
                    if (m_ill < 255) m_ill++;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout mnem=%0d in_ready=%b required 1", m, in_ready);
        end
    endtask

    task automatic rand_legal(input int hi);
        send($urandom_range(0, hi), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 67108863), 1'b1);
    endtask

    task automatic test_reset;
        checks++;
        if ({out_valid, out_instr, out_addr, err, illegal_cnt, in_ready} !== {1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got v=%b i=%h a=%h e=%b c=%0d r=%b required 0/0/0/0/0/1",
                     out_valid, out_instr, out_addr, err, illegal_cnt, in_ready);
        end
    endtask

    task automatic test_add;
        send(0, 1, 2, 3, 0, 0, 1'b0);
        checks++;
        if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h0022_1820, BASE}) begin
            errors++;
            $display("FAIL add_encode got v=%b %h@%h required 1 00221820@%h", out_valid, out_instr, out_addr, BASE);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_pop got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_sequence;
        logic [63:0] e;
        logic [31:0] a0 = m_addr;
        send(10, 0, 8, 0, 0, 26'h3FF_FFFB, 1'b0);
        send(12, 29, 9, 0, 0, 4, 1'b0);
        send(15, 0, 0, 0, 0, 26'h010_0000, 1'b0);
        exp_q.push_back({32'h2008_FFFB, a0});
        exp_q.push_back({32'h8FA9_0004, a0 + 32'd4});
        exp_q.push_back({32'h0810_0000, a0 + 32'd8});
        if (DS) exp_q.push_back({32'h0, a0 + 32'd12});
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_instr, out_addr} !== e) begin
                    errors++;
                    $display("FAIL seq_word got %h@%h required %h@%h", out_instr, out_addr, e[63:32], e[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_drain got left=%0d out_valid=%b required 0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] e;
        for (int i = 0; i < 4; i++) rand_legal(13);
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL bp_full got in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_instr, out_addr} !== exp_q[0]) begin
                errors++;
                $display("FAIL bp_hold got %h@%h required %h@%h", out_instr, out_addr, exp_q[0][63:32], exp_q[0][31:0]);
            end
        end
        out_ready = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if ({out_instr, out_addr} !== e) begin
            errors++;
            $display("FAIL bp_first got %h@%h required %h@%h", out_instr, out_addr, e[63:32], e[31:0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        rand_legal(13);
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_instr, out_addr} !== e) begin
                    errors++;
                    $display("FAIL bp_word got %h@%h required %h@%h", out_instr, out_addr, e[63:32], e[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got left=%0d out_valid=%b required 0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] a;
        logic [63:0] e;
        send(20, 3, 4, 5, 6, 7, 1'b1);
        checks++;
        if ({err, illegal_cnt, out_valid} !== {1'b1, 8'(m_ill), 1'b0}) begin
            errors++;
            $display("FAIL illegal_flag got err=%b cnt=%0d v=%b required 1/%0d/0", err, illegal_cnt, out_valid, m_ill);
        end
        a = m_addr;
        send(8, 7, 5, 4, 2, 0, 1'b1);
        checks++;
        if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h0005_2080, a}) begin
            errors++;
            $display("FAIL illegal_sll got v=%b %h@%h required 1 00052080@%h", out_valid, out_instr, out_addr, a);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_instr, out_addr} !== e) begin
                    errors++;
                    $display("FAIL illegal_word got %h@%h required %h@%h", out_instr, out_addr, e[63:32], e[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_delay_slot;
        logic [31:0] a0 = m_addr;
        logic [63:0] e;
        send(14, 1, 2, 0, 0, 3, 1'b1);
        checks++;
        if (in_ready !== ~DS) begin
            errors++;
            $display("FAIL ds_ready_low got in_ready=%b required %b", in_ready, ~DS);
        end
        checks++;
        if ({out_instr, out_addr} !== {32'h1022_0003, a0}) begin
            errors++;
            $display("FAIL ds_beq got %h@%h required 10220003@%h", out_instr, out_addr, a0);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ds_ready_back got in_ready=%b required 1", in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_instr, out_addr} !== e) begin
                    errors++;
                    $display("FAIL ds_word got %h@%h required %h@%h", out_instr, out_addr, e[63:32], e[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ds_drain got left=%0d out_valid=%b required 0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_random;
        logic [63:0] e;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 2; i++) rand_legal(20);
            checks++;
            if ({err, illegal_cnt} !== {m_err, 8'(m_ill)}) begin
                errors++;
                $display("FAIL rand_err got err=%b cnt=%0d required %b/%0d", err, illegal_cnt, m_err, m_ill);
            end
            out_ready = 1'b1;
            for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
                if (out_valid) begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({out_instr, out_addr} !== e) begin
                        errors++;
                        $display("FAIL rand_word got %h@%h required %h@%h", out_instr, out_addr, e[63:32], e[31:0]);
                    end
                end
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
            checks++;
            if (exp_q.size() != 0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_drain got left=%0d out_valid=%b required 0/0", exp_q.size(), out_valid);
            end
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 260; i++) send(17 + (i % 15), 0, 0, 0, 0, 0, 1'b1);
        checks++;
        if (illegal_cnt !== 8'd255 || err !== 1'b1) begin
            errors++;
            $display("FAIL sat_cnt got cnt=%0d err=%b required 255/1", illegal_cnt, err);
        end
    endtask

    task automatic test_restart;
        logic [63:0] e;
        for (int i = 0; i < 3; i++) rand_legal(13);
        in_valid = 1'b1; in_mnem = 5'd0; restart = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL restart_ready got in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        restart = 1'b0; in_valid = 1'b0;
        exp_q.delete(); m_addr = BASE; m_err = 1'b0;
        checks++;
        if ({out_valid, err} !== 2'b00) begin
            errors++;
            $display("FAIL restart_flush got out_valid=%b err=%b required 0/0", out_valid, err);
        end
        rand_legal(13);
        checks++;
        if (out_addr !== BASE) begin
            errors++;
            $display("FAIL restart_addr got %h required %h", out_addr, BASE);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_instr, out_addr} !== e) begin
                    errors++;
                    $display("FAIL restart_word got %h@%h required %h@%h", out_instr, out_addr, e[63:32], e[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_rstn_mid;
        logic [63:0] e;
        for (int i = 0; i < 2; i++) rand_legal(13);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_instr, out_addr, err, illegal_cnt} !== 74'h0) begin
            errors++;
            $display("FAIL rstn_mid got v=%b i=%h a=%h e=%b c=%0d required all 0",
                     out_valid, out_instr, out_addr, err, illegal_cnt);
        end
        exp_q.delete(); m_addr = BASE; m_err = 1'b0; m_ill = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        rand_legal(16);
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_instr, out_addr} !== e) begin
                    errors++;
                    $display("FAIL rstn_word got %h@%h required %h@%h", out_instr, out_addr, e[63:32], e[31:0]);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstn_drain got left=%0d out_valid=%b required 0/0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        rstn = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
        m_addr = BASE; m_err = 1'b0; m_ill = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rstn = 1'b1;
        @(posedge clk); #1;
        test_add();
        test_sequence();
        test_backpressure();
        test_illegal();
        test_delay_slot();
        test_random();
        test_saturate();
        test_restart();
        test_rstn_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
